spi_slave_rx: RTL

// - SPI slave endpoint for the 16-bit motor-speed link: deserialises mosi into a parallel word and

---
 rtl/spi_slave_rx_if.sv | 23 ++
 rtl/spi_slave_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// SPI slave bus bundle: serial pins from the master plus the parallel
// word/status side seen by the local logic.
interface spi_slave_rx_if #(parameter int DATA_WIDTH = 16);
  logic                  s_clk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  s_clk, cs_n, mosi, tx_data,
    output miso, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output s_clk, cs_n, mosi, tx_data,
    input  miso, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampled SPI slave: synchronises s_clk/cs_n/mosi into clk, samples mosi
// on s_clk falling edges, returns tx_data MSB-first on miso, and reports each
// frame as either a good word (rx_valid) or a bad bit count (frame_err).
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_rx_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] FULL = CW'(W);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_fall, sclk_rise, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   armed;

  state_t         state, state_next;
  logic [W-1:0]   shift_reg, shift_in_val;
  logic [W-2:0]   tx_sr;
  logic [CW-1:0]  bit_cnt, cnt_inc, cnt_after;
  logic           overrun;
  logic           miso_r, rx_valid_r, frame_err_r;
  logic [W-1:0]   rx_data_r;
  logic           do_load, do_shift_in, do_shift_out, do_commit, do_err, set_overrun;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  assign shift_in_val = {shift_reg[W-2:0], mosi_s};
  assign cnt_inc      = (bit_cnt == FULL) ? bit_cnt : bit_cnt + CW'(1);

  // Synchronisers and edge-detect delay flops; idle levels on reset so no
  // phantom edges appear at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.s_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Arm only after the synchroniser holds real samples and cs_n is seen HIGH,
  // so a frame already running at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      if (vld_pipe[SYNC_STAGES] && cs_s) armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and datapath strobes. A cs_rise landing with the last
  // sclk_fall still counts the bit before judging the frame.
  always_comb begin
    state_next   = state;
    do_load      = 1'b0;
    do_shift_in  = 1'b0;
    do_shift_out = 1'b0;
    do_commit    = 1'b0;
    do_err       = 1'b0;
    set_overrun  = 1'b0;
    cnt_after    = bit_cnt;
    case (state)
      IDLE: begin
        if (armed && cs_fall) begin
          do_load    = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        do_shift_in  = sclk_fall;
        cnt_after    = sclk_fall ? cnt_inc : bit_cnt;
        do_shift_out = sclk_rise && (bit_cnt < FULL);
        if (cs_rise) begin
          state_next = IDLE;
          if (cnt_after == FULL) do_commit = 1'b1;
          else                   do_err    = 1'b1;
        end else if (cnt_after == FULL) begin
          state_next = DONE;
        end
      end
      DONE: begin
        set_overrun = sclk_fall;
        if (cs_rise) begin
          state_next = IDLE;
          if (overrun || sclk_fall) do_err    = 1'b1;
          else                      do_commit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shift registers, bit counter, miso and the result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      tx_sr       <= '0;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
      miso_r      <= 1'b0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_valid_r  <= do_commit;
      frame_err_r <= do_err;
      if (do_load) begin
        tx_sr   <= bus.tx_data[W-2:0];
        miso_r  <= bus.tx_data[W-1];
        bit_cnt <= '0;
        overrun <= 1'b0;
      end
      if (do_shift_in) begin
        shift_reg <= shift_in_val;
        bit_cnt   <= cnt_inc;
      end
      if (set_overrun) overrun <= 1'b1;
      if (do_shift_out) begin
        miso_r <= tx_sr[W-2];
        tx_sr  <= {tx_sr[W-3:0], 1'b0};
      end
      if (do_commit) rx_data_r <= do_shift_in ? shift_in_val : shift_reg;
      if (state != IDLE && state_next == IDLE) miso_r <= 1'b0;
    end
  end

  assign bus.miso      = miso_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state != IDLE);
endmodule
